// File: rtl/panel_input_pkg.sv
// Shared constants and types for the front-panel input block.
// The default debounce window is 10 ms at the nominal board clock.
package panel_input_pkg;

  localparam int CLOCK_HZ         = 100_000_000;
  localparam int DEBOUNCE_DEFAULT = CLOCK_HZ / 100;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } button_state_t;

  // Debounced level implied by a button state; the WAIT states keep the old level.
  function automatic logic state_level(button_state_t s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit debouncer: 2-flop synchronizer, stability counter and level register.
// Latency DEBOUNCE_CYCLES+2 edges from first sample to level change; no backpressure.
module debounce_cell
  import panel_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic QUICK_CLOCK,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic flip
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  logic             level_q;
  logic             level_d;
  logic             wait_q;
  logic             wait_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge QUICK_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign sync = sync_q[1];

  // The wait flag mirrors the button FSM's *_WAIT entry edge so both paths share latency.
  always_comb begin
    level_d = level_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    if (sync == level_q) begin
      wait_d = 1'b0;
      cnt_d  = '0;
    end else if (!wait_q) begin
      wait_d = 1'b1;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync;
      wait_d  = 1'b0;
      cnt_d   = '0;
      flip    = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge QUICK_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      wait_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/panel_input.sv
// Front-panel button/switch conditioning: synchronize, debounce, emit level and edge pulses.
// Latency DEBOUNCE_CYCLES+2 edges; pulses are single-cycle and unqualified (no backpressure).
module panel_input
  import panel_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int N_SWITCH        = 4
) (
  input  logic                QUICK_CLOCK,
  input  logic                rst_n,
  input  logic                button,
  input  logic [N_SWITCH-1:0] switch,
  output logic                button_level,
  output logic                button_press,
  output logic                button_release,
  output logic [N_SWITCH-1:0] switch_level,
  output logic                switch_change
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          btn_sync_q;
  logic                btn_sync;
  button_state_t       state_q;
  button_state_t       state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                press_d;
  logic                release_d;
  logic [N_SWITCH-1:0] sw_level;
  logic [N_SWITCH-1:0] sw_flip;

  always_ff @(posedge QUICK_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_q <= 2'b00;
    end else begin
      btn_sync_q <= {btn_sync_q[0], button};
    end
  end

  assign btn_sync = btn_sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered alongside the state so level and pulse change on the same edge.
  always_ff @(posedge QUICK_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RELEASED;
      cnt_q          <= '0;
      button_level   <= 1'b0;
      button_press   <= 1'b0;
      button_release <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      button_level   <= state_level(state_d);
      button_press   <= press_d;
      button_release <= release_d;
    end
  end

  for (genvar i = 0; i < N_SWITCH; i++) begin : g_sw
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .QUICK_CLOCK(QUICK_CLOCK),
      .rst_n      (rst_n),
      .raw        (switch[i]),
      .level      (sw_level[i]),
      .flip       (sw_flip[i])
    );
  end

  // Bits flipping on the same edge collapse into a single change pulse.
  always_ff @(posedge QUICK_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      switch_change <= 1'b0;
    end else begin
      switch_change <= |sw_flip;
    end
  end

  assign switch_level = sw_level;

endmodule

// File: tb/tb_panel_input.sv
// Self-checking bench for panel_input with a 4-cycle debounce window.
// Pulses are matched against a scoreboard of expected (kind, edge, data) events.
module tb_panel_input;

  localparam int D  = 4;
  localparam int NS = 4;
  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_CHANGE  = 2;

  typedef struct {
    int         kind;
    int         cycle;
    logic [3:0] data;
  } ev_t;

  logic          QUICK_CLOCK = 1'b0;
  logic          rst_n;
  logic          button;
  logic [NS-1:0] switch;
  logic          button_level;
  logic          button_press;
  logic          button_release;
  logic [NS-1:0] switch_level;
  logic          switch_change;

  int   ecount = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   press_seen = 0;
  int   release_seen = 0;
  int   change_seen = 0;
  ev_t  exp_q[$];

  panel_input #(
    .DEBOUNCE_CYCLES(D),
    .N_SWITCH       (NS)
  ) dut (
    .QUICK_CLOCK   (QUICK_CLOCK),
    .rst_n         (rst_n),
    .button        (button),
    .switch        (switch),
    .button_level  (button_level),
    .button_press  (button_press),
    .button_release(button_release),
    .switch_level  (switch_level),
    .switch_change (switch_change)
  );

  always #5 QUICK_CLOCK = ~QUICK_CLOCK;

  always @(posedge QUICK_CLOCK) ecount <= ecount + 1;

  function automatic int find_ev(int kind, logic [3:0] data);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].kind == kind && exp_q[i].cycle == ecount &&
          (kind != EV_CHANGE || exp_q[i].data == data))
        return i;
    end
    return -1;
  endfunction

  task automatic push_ev(int kind, int cycle, logic [3:0] data);
    ev_t e;
    e.kind  = kind;
    e.cycle = cycle;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge QUICK_CLOCK);
    #1;
  endtask

  task automatic wait_until(int target);
    while (ecount < target) tick(1);
  endtask

  // Every observed pulse must match a scheduled event on the same edge.
  always @(negedge QUICK_CLOCK) begin
    int idx;
    if (button_press) begin
      press_seen++;
      n_checks++;
      idx = find_ev(EV_PRESS, 4'h0);
      if (idx < 0) $display("FAIL press_pulse: got pulse at edge %0d, required none scheduled there", ecount);
      else begin n_pass++; exp_q.delete(idx); end
    end
    if (button_release) begin
      release_seen++;
      n_checks++;
      idx = find_ev(EV_RELEASE, 4'h0);
      if (idx < 0) $display("FAIL release_pulse: got pulse at edge %0d, required none scheduled there", ecount);
      else begin n_pass++; exp_q.delete(idx); end
    end
    if (switch_change) begin
      change_seen++;
      n_checks++;
      idx = find_ev(EV_CHANGE, switch_level);
      if (idx < 0) $display("FAIL change_pulse: got pulse at edge %0d level %b, required no such event", ecount, switch_level);
      else begin n_pass++; exp_q.delete(idx); end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; button = 1'b0; switch = '0;
    tick(3);
    n_checks++;
    if ({button_level, button_press, button_release, switch_level, switch_change} !== 8'h00)
      $display("FAIL reset_outputs: got %b, required 00000000",
               {button_level, button_press, button_release, switch_level, switch_change});
    else n_pass++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_bounce();
    int p0 = press_seen;
    button = 1'b1;
    tick(3);
    button = 1'b0;
    tick(15);
    n_checks++;
    if (button_level !== 1'b0) $display("FAIL bounce_level: got %b, required 0", button_level);
    else n_pass++;
    n_checks++;
    if (press_seen - p0 !== 0) $display("FAIL bounce_press: got %0d pulses, required 0", press_seen - p0);
    else n_pass++;
  endtask

  task automatic test_press();
    int e = ecount;
    int p0 = press_seen;
    button = 1'b1;
    push_ev(EV_PRESS, e + 7, 4'h0);
    wait_until(e + 6);
    n_checks++;
    if (button_level !== 1'b0) $display("FAIL press_level_early: got %b at edge 5, required 0", button_level);
    else n_pass++;
    wait_until(e + 7);
    n_checks++;
    if (button_level !== 1'b1) $display("FAIL press_level: got %b at edge 6, required 1", button_level);
    else n_pass++;
    wait_until(e + 12);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL press_missing: got %0d pending events, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (press_seen - p0 !== 1) $display("FAIL press_count: got %0d pulses, required 1", press_seen - p0);
    else n_pass++;
  endtask

  task automatic test_release();
    int e = ecount;
    button = 1'b0;
    push_ev(EV_RELEASE, e + 7, 4'h0);
    wait_until(e + 6);
    n_checks++;
    if (button_level !== 1'b1) $display("FAIL release_level_early: got %b at edge 5, required 1", button_level);
    else n_pass++;
    wait_until(e + 7);
    n_checks++;
    if (button_level !== 1'b0) $display("FAIL release_level: got %b at edge 6, required 0", button_level);
    else n_pass++;
    wait_until(e + 12);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL release_missing: got %0d pending events, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (press_seen !== 1 || release_seen !== 1)
      $display("FAIL press_release_total: got %0d/%0d, required 1/1", press_seen, release_seen);
    else n_pass++;
  endtask

  task automatic test_switch();
    int e = ecount;
    switch = 4'b1010;
    push_ev(EV_CHANGE, e + 7, 4'b1010);
    wait_until(e + 6);
    n_checks++;
    if (switch_level !== 4'b0000) $display("FAIL switch_level_early: got %b, required 0000", switch_level);
    else n_pass++;
    wait_until(e + 7);
    n_checks++;
    if (switch_level !== 4'b1010) $display("FAIL switch_level: got %b, required 1010", switch_level);
    else n_pass++;
    wait_until(e + 12);
    // A 2-cycle glitch on bit 0 must not be accepted.
    switch = 4'b1011;
    tick(2);
    switch = 4'b1010;
    tick(12);
    n_checks++;
    if (switch_level !== 4'b1010) $display("FAIL switch_glitch: got %b, required 1010", switch_level);
    else n_pass++;
    n_checks++;
    if (change_seen !== 1) $display("FAIL switch_change_count: got %0d, required 1", change_seen);
    else n_pass++;
    e = ecount;
    switch = 4'b0101;
    push_ev(EV_CHANGE, e + 7, 4'b0101);
    wait_until(e + 7);
    n_checks++;
    if (switch_level !== 4'b0101) $display("FAIL switch_multi: got %b, required 0101", switch_level);
    else n_pass++;
    wait_until(e + 12);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL switch_missing: got %0d pending events, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int e = ecount;
    int r;
    button = 1'b1;
    wait_until(e + 5);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({button_level, button_press, switch_level, switch_change} !== 7'h00)
      $display("FAIL abort_outputs: got %b, required 0000000",
               {button_level, button_press, switch_level, switch_change});
    else n_pass++;
    tick(4);
    rst_n = 1'b1;
    r = ecount;
    push_ev(EV_PRESS, r + 7, 4'h0);
    push_ev(EV_CHANGE, r + 7, 4'b0101);
    wait_until(r + 6);
    n_checks++;
    if (button_level !== 1'b0 || switch_level !== 4'b0000)
      $display("FAIL rearm_early: got %b/%b, required 0/0000", button_level, switch_level);
    else n_pass++;
    wait_until(r + 7);
    n_checks++;
    if (button_level !== 1'b1 || switch_level !== 4'b0101)
      $display("FAIL rearm_level: got %b/%b, required 1/0101", button_level, switch_level);
    else n_pass++;
    wait_until(r + 12);
    e = ecount;
    button = 1'b0;
    push_ev(EV_RELEASE, e + 7, 4'h0);
    wait_until(e + 12);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rearm_missing: got %0d pending events, required 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    button = 1'b0;
    switch = '0;
    #1;
    test_reset();
    test_bounce();
    test_press();
    test_release();
    test_switch();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
